// File: rtl/rr_onehot_arbiter_if.sv
// Request/grant bundle between the request sources, the round-robin arbiter
// and the downstream 8-to-3 encoder.
interface rr_onehot_arbiter_if;
  logic [7:0] req;
  logic       gnt_ack;
  logic [7:0] grant;
  logic       gnt_valid;
  logic [7:0] pending;
  logic       timeout;

  // master: request sources plus the grant consumer; slave: the arbiter
  modport master (
    output req,
    output gnt_ack,
    input  grant,
    input  gnt_valid,
    input  pending,
    input  timeout
  );

  modport slave (
    input  req,
    input  gnt_ack,
    output grant,
    output gnt_valid,
    output pending,
    output timeout
  );
endinterface

// File: rtl/rr_onehot_arbiter.sv
// 8-source round-robin arbiter with sticky pending bits, a registered one-hot
// grant held until acknowledged, and a timeout that withdraws a stuck grant.
module rr_onehot_arbiter #(
  parameter int N       = 8,
  parameter int TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst,
  rr_onehot_arbiter_if.slave bus
);

  localparam int PW = $clog2(N);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state;
  logic [N-1:0]   pending_q;
  logic [N-1:0]   grant_q;
  logic           valid_q;
  logic           timeout_q;
  logic [PW-1:0]  ptr;
  logic [7:0]     cnt;

  logic [N-1:0]   sel_onehot;
  logic           sel_found;
  logic [PW-1:0]  scan_idx;
  logic [PW-1:0]  grant_idx;
  logic [N-1:0]   clr;

  // Wrap-around priority search starting at the pointer.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel_onehot = '0;
    sel_found  = 1'b0;
    scan_idx   = '0;
    for (int i = 0; i < N; i++) begin
      scan_idx = ptr + PW'(i);
      if (!sel_found && pending_q[scan_idx]) begin
        sel_onehot[scan_idx] = 1'b1;
        sel_found            = 1'b1;
      end
    end
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) grant_idx = PW'(i);
    end
  end

  assign clr = (state == GRANT && bus.gnt_ack) ? grant_q : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pending_q <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      // Set wins over clear so a re-request on the ack edge is not lost.
      pending_q <= (pending_q & ~clr) | bus.req;
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (|pending_q) begin
            grant_q <= sel_onehot;
            valid_q <= 1'b1;
            cnt     <= '0;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (bus.gnt_ack) begin
            grant_q <= '0;
            valid_q <= 1'b0;
            ptr     <= grant_idx + PW'(1);
            state   <= IDLE;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            // Withdraw but keep the pending bit; the source retries later.
            grant_q   <= '0;
            valid_q   <= 1'b0;
            ptr       <= grant_idx + PW'(1);
            timeout_q <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.gnt_valid = valid_q;
  assign bus.pending   = pending_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Scenario bench for rr_onehot_arbiter: expected grants are queued when
// requests are driven and popped as each new grant appears.
module tb_rr_onehot_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] exp_q[$];

  rr_onehot_arbiter_if bus ();

  rr_onehot_arbiter #(.N(8), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic reset_dut();
    @(negedge clk);
    rst         = 1'b1;
    bus.req     = 8'h00;
    bus.gnt_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Drive req for exactly one edge; returns at the following negedge.
  task automatic pulse_req(input logic [7:0] r);
    bus.req = r;
    @(negedge clk);
    bus.req = 8'h00;
  endtask

  // Wait for gnt_valid, then pop the expected grant and compare.
  task automatic wait_grant(input int budget, output int waited);
    logic [7:0] exp_g;
    bit seen;
    seen   = 1'b0;
    waited = 0;
    while (!seen && waited < budget) begin
      @(negedge clk);
      waited++;
      seen = (bus.gnt_valid === 1'b1);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: grant seen=%0b but no expected grant queued", seen);
    end else begin
      exp_g = exp_q.pop_front();
      if (!seen) begin
        errors++;
        $display("FAIL grant_wait: no gnt_valid within %0d cycles, expected grant %h", budget, exp_g);
      end else if (bus.grant !== exp_g) begin
        errors++;
        $display("FAIL grant_value: got %h expected %h", bus.grant, exp_g);
      end
    end
  endtask

  task automatic test_reset();
    int w;
    rst         = 1'b1;
    bus.req     = 8'h00;
    bus.gnt_ack = 1'b0;
    #1;
    checks++;
    if ({bus.grant, bus.gnt_valid, bus.pending, bus.timeout} !== 18'h0) begin
      errors++;
      $display("FAIL reset_initial: grant=%h valid=%b pending=%h timeout=%b expected all zero",
               bus.grant, bus.gnt_valid, bus.pending, bus.timeout);
    end
    @(negedge clk);
    rst = 1'b0;
    pulse_req(8'h0C);
    exp_q.push_back(8'h04);
    wait_grant(4, w);
    checks++;
    if (bus.pending !== 8'h0C) begin
      errors++;
      $display("FAIL reset_setup_pending: got %h expected 0c", bus.pending);
    end
    // Assert reset between edges; outputs must clear before the next edge.
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.grant, bus.gnt_valid, bus.pending, bus.timeout} !== 18'h0) begin
      errors++;
      $display("FAIL reset_async: grant=%h valid=%b pending=%h timeout=%b expected all zero",
               bus.grant, bus.gnt_valid, bus.pending, bus.timeout);
    end
    @(negedge clk);
    rst = 1'b0;
    pulse_req(8'h81);
    exp_q.push_back(8'h01);
    wait_grant(4, w);
  endtask

  task automatic test_single();
    int w;
    reset_dut();
    pulse_req(8'h08);
    checks++;
    if (bus.pending !== 8'h08 || bus.gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_edge1: pending=%h valid=%b expected 08/0", bus.pending, bus.gnt_valid);
    end
    exp_q.push_back(8'h08);
    wait_grant(1, w);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus.grant !== 8'h08 || bus.gnt_valid !== 1'b1 || bus.timeout !== 1'b0) begin
        errors++;
        $display("FAIL single_hold[%0d]: grant=%h valid=%b timeout=%b expected 08/1/0",
                 k, bus.grant, bus.gnt_valid, bus.timeout);
      end
    end
    bus.gnt_ack = 1'b1;
    @(negedge clk);
    bus.gnt_ack = 1'b0;
    checks++;
    if (bus.pending !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.grant !== 8'h00) begin
      errors++;
      $display("FAIL single_ack: pending=%h valid=%b grant=%h expected 00/0/00",
               bus.pending, bus.gnt_valid, bus.grant);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    reset_dut();
    bus.gnt_ack = 1'b1;
    pulse_req(8'hFF);
    for (int g = 0; g < 8; g++) exp_q.push_back(8'h01 << g);
    for (int g = 0; g < 8; g++) begin
      wait_grant(6, w);
      if (g > 0) begin
        checks++;
        if (w != 2) begin
          errors++;
          $display("FAIL b2b_spacing[%0d]: got %0d cycles expected 2", g, w);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (bus.pending !== 8'h00 || bus.gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: pending=%h valid=%b expected 00/0", bus.pending, bus.gnt_valid);
    end
    bus.gnt_ack = 1'b0;
  endtask

  task automatic test_wrap();
    int w;
    bus.gnt_ack = 1'b1;
    pulse_req(8'h10);
    exp_q.push_back(8'h10);
    wait_grant(4, w);
    // Pointer becomes 5 on this ack edge; 0x44 must go 6 first, then wrap to 2.
    pulse_req(8'h44);
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h04);
    wait_grant(4, w);
    wait_grant(4, w);
    // Pointer should now be 3: 0x0A resolves source 3 before source 1.
    pulse_req(8'h0A);
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h02);
    wait_grant(4, w);
    wait_grant(4, w);
    @(negedge clk);
    bus.gnt_ack = 1'b0;
    checks++;
    if (bus.pending !== 8'h00) begin
      errors++;
      $display("FAIL wrap_end: pending=%h expected 00", bus.pending);
    end
  endtask

  task automatic test_timeout();
    int w;
    reset_dut();
    pulse_req(8'h06);
    exp_q.push_back(8'h02);
    wait_grant(4, w);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++;
      if (k < 16) begin
        if (bus.gnt_valid !== 1'b1 || bus.timeout !== 1'b0 || bus.grant !== 8'h02) begin
          errors++;
          $display("FAIL timeout_hold[%0d]: valid=%b timeout=%b grant=%h expected 1/0/02",
                   k, bus.gnt_valid, bus.timeout, bus.grant);
        end
      end else begin
        if (bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b1 || bus.pending !== 8'h06 ||
            bus.grant !== 8'h00) begin
          errors++;
          $display("FAIL timeout_fire: valid=%b timeout=%b pending=%h grant=%h expected 0/1/06/00",
                   bus.gnt_valid, bus.timeout, bus.pending, bus.grant);
        end
      end
    end
    exp_q.push_back(8'h04);
    wait_grant(1, w);
    checks++;
    if (bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse_width: timeout=%b expected 0", bus.timeout);
    end
  endtask

  task automatic test_ack_set_collision();
    int w;
    reset_dut();
    pulse_req(8'h0A);
    exp_q.push_back(8'h02);
    wait_grant(4, w);
    bus.req     = 8'h02;
    bus.gnt_ack = 1'b1;
    @(negedge clk);
    bus.req = 8'h00;
    checks++;
    if (bus.pending !== 8'h0A || bus.gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL collision_pending: pending=%h valid=%b expected 0a/0", bus.pending, bus.gnt_valid);
    end
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h02);
    wait_grant(4, w);
    wait_grant(4, w);
    @(negedge clk);
    bus.gnt_ack = 1'b0;
    checks++;
    if (bus.pending !== 8'h00) begin
      errors++;
      $display("FAIL collision_end: pending=%h expected 00", bus.pending);
    end
  endtask

  task automatic test_idle_ack();
    int w;
    bus.gnt_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt_valid !== 1'b0 || bus.grant !== 8'h00 || bus.pending !== 8'h00 ||
          bus.timeout !== 1'b0) begin
        errors++;
        $display("FAIL idle_ack[%0d]: valid=%b grant=%h pending=%h timeout=%b expected all zero",
                 k, bus.gnt_valid, bus.grant, bus.pending, bus.timeout);
      end
    end
    bus.gnt_ack = 1'b0;
    // Pointer is 2 here: 0x03 wraps to source 0 first, then source 1.
    pulse_req(8'h03);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    wait_grant(4, w);
    bus.gnt_ack = 1'b1;
    wait_grant(4, w);
    @(negedge clk);
    bus.gnt_ack = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_timeout();
    test_ack_set_collision();
    test_idle_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- 8-source round-robin request arbiter that sits directly upstream of the 8-to-3 encoder.
- Captures request pulses into sticky pending bits and selects one source fairly.
- Presents exactly one hot grant bit, plus a valid flag that drives the encoder enable, and holds it until the consumer acknowledges.
- A timeout counter recovers from a consumer that never acknowledges.

Parameters:
- N, 8, number of request sources. Fixed at 8 to match the encoder input width; other values are unsupported.
- TIMEOUT, 16, number of cycles a grant may stay un-acked before it is withdrawn. Legal range 2..255; the counter is 8 bits.

Ports:
- clk  input  1  system clock; rising edge active.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request lines; any cycle with req[i]=1 sets pending[i].
- gnt_ack  input  1  consumer accepts the current grant; sampled only while gnt_valid=1.
- grant  output  8  registered one-hot grant; 8'h00 when no grant is active. Feeds encoder din.
- gnt_valid  output  1  grant is active. Feeds encoder en.
- pending  output  8  sticky pending request bits (status).
- timeout  output  1  one-cycle pulse when a grant is withdrawn by timeout.

Behaviour:
- Reset (async, rst=1): grant=8'h00, gnt_valid=0, pending=8'h00, timeout=0, pointer=3'd0, counter=0, state=IDLE. All outputs take these values immediately, not at the next edge.
- Pending update each edge: pending_next = (pending & ~clr) | req.
  - clr is the granted one-hot on an ack edge, else 0.
  - Set wins over clear: req[i]=1 on the ack edge for source i leaves pending[i]=1.
- Selection: first set bit of pending searching pointer, pointer+1, ... mod 8 (wrap-around). At reset source 0 has top priority.
- FSM states:
  - IDLE:
    - gnt_valid=0, grant=0.
    - If pending!=0 at an edge: register the selected one-hot into grant, set gnt_valid=1, counter=0, go to GRANT.
    - The decision uses registered pending, so a req sampled at edge k gives grant visible after edge k+1 (2-edge latency from an idle bench).
  - GRANT: grant held stable; counter increments each edge.
    - gnt_ack=1: clear that pending bit, pointer = granted index + 1 (mod 8), grant=0, gnt_valid=0, go to IDLE.
    - Otherwise, counter reaches TIMEOUT-1 with no ack: withdraw the grant (grant=0, gnt_valid=0), keep the pending bit, pointer = granted index + 1, timeout=1 for one cycle, go to IDLE.
    - Ack and timeout on the same edge: ack wins and timeout stays 0.
- Minimum spacing between consecutive grants is 2 cycles: one IDLE bubble guarantees gnt_valid drops for a cycle between grants.
- gnt_ack while gnt_valid=0 is ignored.
- grant is always 0 or exactly one-hot, never multi-hot.
- grant changes only on IDLE→GRANT and GRANT→IDLE transitions.
- Reset asserted during GRANT aborts the grant and discards all pending bits.

Test Plan:
- rst pulsed asynchronously mid-cycle while gnt_valid=1 and pending=8'h0C -> grant=8'h00, gnt_valid=0, pending=8'h00 before the next clk edge; after release, source 0 has top priority.
- Single-cycle req=8'h08 from IDLE -> pending=8'h08 after edge 1; grant=8'h08 and gnt_valid=1 after edge 2; held with no ack for 5 cycles; ack -> pending=8'h00, gnt_valid=0 on the next edge.
- req=8'hFF for one cycle, gnt_ack held at 1 -> grants 8'h01, 8'h02, ..., 8'h80 in order, one every 2 cycles; gnt_valid toggles 1/0; pending ends at 8'h00.
- Pointer at 5 (after granting source 4) with pending=8'h44 -> grant=8'h40 first, then 8'h04 (wrap); pointer ends at 3.
- TIMEOUT=16, grant=8'h02 with pending=8'h06 and no ack -> timeout=1 for exactly one cycle after 16 cycles in GRANT; gnt_valid=0; pending still 8'h06; next grant=8'h04.
- Ack for source 1 on the same edge that req[1]=1 -> pending[1] stays 1 and source 1 is regranted after the other pending sources. Separately, gnt_ack=1 during IDLE -> no state or pending change.
